// File: rtl/sensor_sched_pkg.sv
// -----------------------------------------------------------------------------
// sensor_sched_pkg
// Shared definitions for the DHT sensor read scheduler:
//   - FSM state encoding of the scheduler
//   - response status codes
//   - byte field offsets inside the 40-bit DHT reader result
//   - checksum helper functions (modulo-256 sum of the four data bytes)
// No ports; imported by the scheduler, its interface and its request queue.
// -----------------------------------------------------------------------------
package sensor_sched_pkg;

    localparam int SENSOR_W = 5;
    localparam int DATA_W   = 40;

    // Byte field offsets of {hum_int, hum_float, temp_int, temp_float, check_sum}
    localparam int HUM_INT_LSB    = 32;
    localparam int HUM_FLOAT_LSB  = 24;
    localparam int TEMP_INT_LSB   = 16;
    localparam int TEMP_FLOAT_LSB = 8;
    localparam int CHECK_SUM_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_BUSY    = 3'd2,
        ST_RESPOND = 3'd3,
        ST_GUARD   = 3'd4
    } sched_state_e;

    typedef enum logic [1:0] {
        RSP_OK         = 2'd0,
        RSP_SENSOR_ERR = 2'd1,
        RSP_TIMEOUT    = 2'd2,
        RSP_CKSUM_ERR  = 2'd3
    } rsp_status_e;

    // Modulo-256 sum of the four data bytes (carry out is dropped on purpose)
    function automatic logic [7:0] dht_byte_sum(input logic [DATA_W-1:0] data);
        logic [7:0] sum;
        sum = data[HUM_INT_LSB +: 8] + data[HUM_FLOAT_LSB +: 8]
            + data[TEMP_INT_LSB +: 8] + data[TEMP_FLOAT_LSB +: 8];
        return sum;
    endfunction

    // True when the transmitted check_sum byte matches the recomputed sum
    function automatic logic dht_checksum_ok(input logic [DATA_W-1:0] data);
        return (dht_byte_sum(data) == data[CHECK_SUM_LSB +: 8]);
    endfunction

endpackage

// File: rtl/sensor_scheduler_if.sv
// -----------------------------------------------------------------------------
// sensor_scheduler_if
// Bundles the three handshakes of the scheduler:
//   request side : req_valid/req_ready/req_sensor
//   reader side  : dht_start/dht_index out, dht_done/dht_error/dht_data in
//   response side: rsp_valid/rsp_ready/rsp_sensor/rsp_data/rsp_status
// modport slave  : the scheduler's view
// modport master : the environment's view (requester, reader, consumer)
// -----------------------------------------------------------------------------
interface sensor_scheduler_if;
    import sensor_sched_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [SENSOR_W-1:0] req_sensor;

    logic                dht_start;
    logic [SENSOR_W-1:0] dht_index;
    logic                dht_done;
    logic                dht_error;
    logic [DATA_W-1:0]   dht_data;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [SENSOR_W-1:0] rsp_sensor;
    logic [DATA_W-1:0]   rsp_data;
    logic [1:0]          rsp_status;

    modport slave (
        input  req_valid, req_sensor,
        output req_ready,
        output dht_start, dht_index,
        input  dht_done, dht_error, dht_data,
        output rsp_valid, rsp_sensor, rsp_data, rsp_status,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_sensor,
        input  req_ready,
        input  dht_start, dht_index,
        output dht_done, dht_error, dht_data,
        input  rsp_valid, rsp_sensor, rsp_data, rsp_status,
        output rsp_ready
    );

endinterface

// File: rtl/sensor_req_fifo.sv
// -----------------------------------------------------------------------------
// sensor_req_fifo
// Request queue of the scheduler: synchronous FIFO, power-of-two depth.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (empties the queue)
//   push_i       : write push_data_i (ignored when full)
//   push_data_i  : request payload (sensor index)
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : current head entry, valid while empty_o is low
//   empty_o      : queue holds no entry
//   not_full_o   : count < DEPTH, from the registered count only
// -----------------------------------------------------------------------------
module sensor_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             not_full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign not_full_o = (count_q < CNT_W'(DEPTH));
    assign empty_o    = (count_q == CNT_W'(0));
    assign head_o     = mem_q[rd_ptr_q];
    assign do_push_s  = push_i && not_full_o;
    assign do_pop_s   = pop_i && !empty_o;

    // Next pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/sensor_scheduler.sv
// -----------------------------------------------------------------------------
// sensor_scheduler
// Serialises sensor read requests onto a single DHT reader. Requests are
// queued, issued one at a time with a one-cycle dht_start pulse, supervised
// by a timeout, returned through a valid/ready response port, and followed
// by a guard gap of idle clocks before the next read.
// Ports:
//   clk   : 1 MHz system clock, rising edge
//   reset : synchronous, active-high
//   bus   : sensor_scheduler_if.slave (request, reader and response signals)
// Parameters:
//   FIFO_DEPTH : request queue depth (power of two, >= 2)
//   GUARD_US   : idle clocks after every transaction and after reset
//   TIMEOUT_US : clocks from dht_start before a read is declared timed out
// Build option:
//   SENSOR_SCHED_CHECKSUM_EN : when defined, the reader's check_sum byte is
//   verified and a mismatch (without dht_error) reports status 3.
// -----------------------------------------------------------------------------
module sensor_scheduler
    import sensor_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GUARD_US   = 1000,
    parameter int TIMEOUT_US = 25000
) (
    input  logic              clk,
    input  logic              reset,
    sensor_scheduler_if.slave bus
);

    localparam int TIMER_W = $clog2(TIMEOUT_US + 1);
    localparam int GUARD_W = $clog2(GUARD_US + 1);

    sched_state_e        state_q, state_d;
    logic [SENSOR_W-1:0] dht_index_q, dht_index_d;
    logic                dht_start_q, dht_start_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [GUARD_W-1:0]  guard_q, guard_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [SENSOR_W-1:0] rsp_sensor_q, rsp_sensor_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]          rsp_status_q, rsp_status_d;

    logic                fifo_push_s;
    logic                fifo_pop_s;
    logic [SENSOR_W-1:0] fifo_head_s;
    logic                fifo_empty_s;
    logic                fifo_not_full_s;
    rsp_status_e         done_status_s;

    // Ready is forced low while reset is held so nothing is accepted into a queue being cleared
    assign bus.req_ready = !reset && fifo_not_full_s;
    assign fifo_push_s   = bus.req_valid && bus.req_ready;

    assign bus.dht_start  = dht_start_q;
    assign bus.dht_index  = dht_index_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_sensor = rsp_sensor_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_status = rsp_status_q;

    sensor_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SENSOR_W)
    ) u_req_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push_s),
        .push_data_i (bus.req_sensor),
        .pop_i       (fifo_pop_s),
        .head_o      (fifo_head_s),
        .empty_o     (fifo_empty_s),
        .not_full_o  (fifo_not_full_s)
    );

    // Status of a completed read: reader error outranks a checksum mismatch
    always_comb begin
        done_status_s = RSP_OK;
        if (bus.dht_error) begin
            done_status_s = RSP_SENSOR_ERR;
`ifdef SENSOR_SCHED_CHECKSUM_EN
        end else if (!dht_checksum_ok(bus.dht_data)) begin
            done_status_s = RSP_CKSUM_ERR;
`endif
        end else begin
            done_status_s = RSP_OK;
        end
    end

    // Scheduler FSM: next state, queue pop and response capture
    always_comb begin
        state_d      = state_q;
        dht_index_d  = dht_index_q;
        dht_start_d  = 1'b0;
        timer_d      = timer_q;
        guard_d      = guard_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_sensor_d = rsp_sensor_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        fifo_pop_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s  = 1'b1;
                    dht_index_d = fifo_head_s;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            // The start pulse is registered, so it appears in the first BUSY cycle
            // together with timer_q == 0.
            ST_ISSUE: begin
                dht_start_d = 1'b1;
                timer_d     = TIMER_W'(0);
                state_d     = ST_BUSY;
            end

            // Completion is tested before the timeout so a done on the final
            // cycle still counts as a good read.
            ST_BUSY: begin
                if (bus.dht_done) begin
                    rsp_valid_d  = 1'b1;
                    rsp_sensor_d = dht_index_q;
                    rsp_data_d   = bus.dht_data;
                    rsp_status_d = done_status_s;
                    state_d      = ST_RESPOND;
                end else if (timer_q == TIMER_W'(TIMEOUT_US - 1)) begin
                    rsp_valid_d  = 1'b1;
                    rsp_sensor_d = dht_index_q;
                    rsp_data_d   = {DATA_W{1'b0}};
                    rsp_status_d = RSP_TIMEOUT;
                    state_d      = ST_RESPOND;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            ST_RESPOND: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    guard_d     = GUARD_W'(0);
                    state_d     = ST_GUARD;
                end else begin
                    state_d = ST_RESPOND;
                end
            end

            ST_GUARD: begin
                if (guard_q == GUARD_W'(GUARD_US - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q + GUARD_W'(1);
                end
            end

            default: begin
                guard_d = GUARD_W'(0);
                state_d = ST_GUARD;
            end
        endcase
    end

    // State and output registers; reset lands in GUARD so a reader that
    // cannot be reset gets time to finish its current transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_GUARD;
            dht_index_q  <= SENSOR_W'(0);
            dht_start_q  <= 1'b0;
            timer_q      <= TIMER_W'(0);
            guard_q      <= GUARD_W'(0);
            rsp_valid_q  <= 1'b0;
            rsp_sensor_q <= SENSOR_W'(0);
            rsp_data_q   <= {DATA_W{1'b0}};
            rsp_status_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            dht_index_q  <= dht_index_d;
            dht_start_q  <= dht_start_d;
            timer_q      <= timer_d;
            guard_q      <= guard_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_sensor_q <= rsp_sensor_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

endmodule
